// File: rtl/fir_run_ctrl.sv
// Run sequencer and port-A arbiter for the FIR subsystem: launches one engine per run,
// times the run, and lends sample-memory port A to either the host loader or the active engine.
module fir_run_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              start,
    input  logic              sel_pipelined,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              eng_start_np,
    output logic              eng_start_p,
    input  logic              eng_done_np,
    input  logic              eng_done_p,
    input  logic [ADDR_W-1:0] eng_addr_a,
    input  logic              eng_we_a,
    input  logic [DATA_W-1:0] eng_wdata_a,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic              mem_we_a,
    output logic [DATA_W-1:0] mem_data_in_a,
    input  logic [DATA_W-1:0] mem_data_out_a
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

    state_t             state_r, state_nxt_s;
    logic               sel_r, sel_nxt_s;
    logic               timeout_err_r, tmo_nxt_s;
    logic [CNT_W-1:0]   cycle_count_r, count_nxt_s, count_inc_s;
    logic               busy_r, done_r, eng_start_np_r, eng_start_p_r, host_rvalid_r;
    logic               eng_done_sel_s;

    // Saturating increment; done only counts from the engine picked at launch.
    assign count_inc_s    = (cycle_count_r == CNT_MAX_C) ? cycle_count_r : cycle_count_r + CNT_ONE_C;
    assign eng_done_sel_s = sel_r ? eng_done_p : eng_done_np;

    // Next-state, run counter, engine latch and timeout flag.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        count_nxt_s = cycle_count_r;
        tmo_nxt_s   = timeout_err_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sel_nxt_s   = sel_pipelined;
                    count_nxt_s = {CNT_W{1'b0}};
                    tmo_nxt_s   = 1'b0;
                    state_nxt_s = ST_LAUNCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                count_nxt_s = count_inc_s;
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                count_nxt_s = count_inc_s;
                if (eng_done_sel_s) begin
                    state_nxt_s = ST_DONE;
                end else if (count_inc_s >= TIMEOUT_C) begin
                    tmo_nxt_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            sel_r          <= 1'b0;
            cycle_count_r  <= {CNT_W{1'b0}};
            timeout_err_r  <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            eng_start_np_r <= 1'b0;
            eng_start_p_r  <= 1'b0;
            host_rvalid_r  <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            sel_r          <= sel_nxt_s;
            cycle_count_r  <= count_nxt_s;
            timeout_err_r  <= tmo_nxt_s;
            busy_r         <= (state_nxt_s != ST_IDLE);
            done_r         <= (state_nxt_s == ST_DONE);
            eng_start_np_r <= (state_nxt_s == ST_LAUNCH) && !sel_nxt_s;
            eng_start_p_r  <= (state_nxt_s == ST_LAUNCH) && sel_nxt_s;
            host_rvalid_r  <= host_gnt && !host_we;
        end
    end

    // Port-A mux: host owns it in IDLE; engine otherwise, with writes blocked in DONE.
    always_comb begin
        host_gnt      = 1'b0;
        mem_addr_a    = eng_addr_a;
        mem_we_a      = 1'b0;
        mem_data_in_a = eng_wdata_a;
        case (state_r)
            ST_IDLE: begin
                host_gnt      = host_req;
                mem_addr_a    = host_addr;
                mem_we_a      = host_req && host_we;
                mem_data_in_a = host_wdata;
            end
            ST_LAUNCH, ST_RUN: begin
                mem_we_a = eng_we_a;
            end
            ST_DONE: begin
                mem_we_a = 1'b0;
            end
            default: begin
                mem_we_a = 1'b0;
            end
        endcase
    end

    assign host_rvalid  = host_rvalid_r;
    assign host_rdata   = host_rvalid_r ? mem_data_out_a : {DATA_W{1'b0}};
    assign busy         = busy_r;
    assign done         = done_r;
    assign timeout_err  = timeout_err_r;
    assign cycle_count  = cycle_count_r;
    assign eng_start_np = eng_start_np_r;
    assign eng_start_p  = eng_start_p_r;

endmodule
